// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module  : hazard_ctrl_pkg
// Brief   : Shared constants, state encodings and helpers for hazard_ctrl.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;

    localparam logic [1:0] c_ST_RUN     = 2'd0;
    localparam logic [1:0] c_ST_MEMWAIT = 2'd1;
    localparam logic [1:0] c_ST_KILL    = 2'd2;

    typedef struct packed {
        logic stall_IF;
        logic stall_ID;
        logic stall_X;
        logic bubble_X;
        logic kill_ID;
        logic pc_redirect;
    } ctrl_t;

    // A load in X whose non-x0 destination feeds a source ID really reads.
    function automatic logic is_load_use(
        input logic [6:0] opcode_X,
        input logic       rf_wen_X,
        input logic [4:0] rd_X,
        input logic [4:0] rs1_ID,
        input logic [4:0] rs2_ID,
        input logic       use_rs1_ID,
        input logic       use_rs2_ID
    );
        return (opcode_X == c_OPC_LOAD) && rf_wen_X && (rd_X != 5'd0) &&
               ((use_rs1_ID && (rd_X == rs1_ID)) ||
                (use_rs2_ID && (rd_X == rs2_ID)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module  : hazard_ctrl_if
// Brief   : Pipeline-side signal bundle between the core stages and hazard_ctrl.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode_X;
    logic             rf_wen_X;
    logic [4:0]       rd_X;
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic             use_rs1_ID;
    logic             use_rs2_ID;
    logic             br_taken_X;
    logic             jump_X;
    logic             mem_req_X;
    logic             mem_ready;
    logic             cnt_clr;

    logic             stall_IF;
    logic             stall_ID;
    logic             stall_X;
    logic             bubble_X;
    logic             kill_ID;
    logic             pc_redirect;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output opcode_X, rf_wen_X, rd_X, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID,
               br_taken_X, jump_X, mem_req_X, mem_ready, cnt_clr,
        input  stall_IF, stall_ID, stall_X, bubble_X, kill_ID, pc_redirect,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  opcode_X, rf_wen_X, rd_X, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID,
               br_taken_X, jump_X, mem_req_X, mem_ready, cnt_clr,
        output stall_IF, stall_ID, stall_X, bubble_X, kill_ID, pc_redirect,
               stall_cnt, flush_cnt
    );

endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_perf_counter.sv
// ============================================================================
// Module  : hazard_ctrl_perf_counter
// Brief   : Wrapping event counter with synchronous clear (clear beats increment).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module  : hazard_ctrl
// Brief   : 3-stage pipe sequencer: load-use interlock, memory wait, redirect kill.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int KILL_CYC = 1,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    localparam logic [1:0] c_KILL_RELOAD = 2'(KILL_CYC - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_kcnt;
    logic [1:0]       w_kcnt_nxt;
    ctrl_t            w_ctrl;
    logic             w_load_use;
    logic             w_redir;
    logic             w_mem_wait;
    logic             w_stall_IF;
    logic             w_kill_ID;
    logic [CNT_W-1:0] w_stall_cnt;
    logic [CNT_W-1:0] w_flush_cnt;

    assign w_load_use = is_load_use(hz.opcode_X, hz.rf_wen_X, hz.rd_X,
                                    hz.rs1_ID, hz.rs2_ID,
                                    hz.use_rs1_ID, hz.use_rs2_ID);
    assign w_redir    = hz.br_taken_X | hz.jump_X;
    assign w_mem_wait = hz.mem_req_X & ~hz.mem_ready;

    always_comb begin
        w_ctrl      = '0;
        w_state_nxt = r_state;
        w_kcnt_nxt  = r_kcnt;
        case (r_state)
            c_ST_RUN: begin
                if (w_mem_wait) begin
                    w_ctrl.stall_IF = 1'b1;
                    w_ctrl.stall_ID = 1'b1;
                    w_ctrl.stall_X  = 1'b1;
                    w_state_nxt     = c_ST_MEMWAIT;
                end else if (w_redir) begin
                    // ID holds a wrong-path instruction, so any load-use on it is moot.
                    w_ctrl.pc_redirect = 1'b1;
                    w_ctrl.kill_ID     = 1'b1;
                    if (KILL_CYC > 1) begin
                        w_state_nxt = c_ST_KILL;
                        w_kcnt_nxt  = c_KILL_RELOAD;
                    end
                end else if (w_load_use) begin
                    w_ctrl.stall_IF = 1'b1;
                    w_ctrl.stall_ID = 1'b1;
                    w_ctrl.bubble_X = 1'b1;
                end
            end
            c_ST_MEMWAIT: begin
                if (!hz.mem_ready) begin
                    w_ctrl.stall_IF = 1'b1;
                    w_ctrl.stall_ID = 1'b1;
                    w_ctrl.stall_X  = 1'b1;
                end else begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_KILL: begin
                w_ctrl.kill_ID = 1'b1;
                if (w_redir) begin
                    w_ctrl.pc_redirect = 1'b1;
                    w_kcnt_nxt         = c_KILL_RELOAD;
                end else if (r_kcnt <= 2'd1) begin
                    w_kcnt_nxt  = 2'd0;
                    w_state_nxt = c_ST_RUN;
                end else begin
                    w_kcnt_nxt = r_kcnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_RUN;
                w_kcnt_nxt  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_RUN;
            r_kcnt  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_kcnt  <= w_kcnt_nxt;
        end
    end

    // Outputs are forced low for the whole time reset is asserted.
    assign w_stall_IF     = w_ctrl.stall_IF & rst_n;
    assign w_kill_ID      = w_ctrl.kill_ID  & rst_n;
    assign hz.stall_IF    = w_stall_IF;
    assign hz.stall_ID    = w_ctrl.stall_ID    & rst_n;
    assign hz.stall_X     = w_ctrl.stall_X     & rst_n;
    assign hz.bubble_X    = w_ctrl.bubble_X    & rst_n;
    assign hz.kill_ID     = w_kill_ID;
    assign hz.pc_redirect = w_ctrl.pc_redirect & rst_n;

    hazard_ctrl_perf_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_stall_IF),
        .i_clr (hz.cnt_clr),
        .o_cnt (w_stall_cnt)
    );

    hazard_ctrl_perf_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_kill_ID),
        .i_clr (hz.cnt_clr),
        .o_cnt (w_flush_cnt)
    );

    assign hz.stall_cnt = w_stall_cnt;
    assign hz.flush_cnt = w_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Directed self-checking bench for hazard_ctrl (KILL_CYC=2, CNT_W=4).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam logic [6:0] c_LOAD = 7'b0000011;
    localparam logic [6:0] c_ALU  = 7'b0110011;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    hazard_ctrl_if #(.CNT_W(4)) hz ();

    hazard_ctrl #(
        .KILL_CYC (2),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output order: stall_IF stall_ID stall_X bubble_X kill_ID pc_redirect
    task automatic chk_o(input string tag, input logic [5:0] exp);
        chk(tag, 32'({hz.stall_IF, hz.stall_ID, hz.stall_X,
                      hz.bubble_X, hz.kill_ID, hz.pc_redirect}), 32'(exp));
    endtask

    task automatic drv_x(input logic [6:0] opc, input logic wen, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
        hz.opcode_X   = opc;
        hz.rf_wen_X   = wen;
        hz.rd_X       = rd;
        hz.rs1_ID     = rs1;
        hz.use_rs1_ID = u1;
        hz.rs2_ID     = rs2;
        hz.use_rs2_ID = u2;
    endtask

    task automatic idle();
        drv_x(c_ALU, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        hz.br_taken_X = 1'b0;
        hz.jump_X     = 1'b0;
        hz.mem_req_X  = 1'b0;
        hz.mem_ready  = 1'b0;
        hz.cnt_clr    = 1'b0;
    endtask

    // Advance to just after the next rising edge; callers re-drive then settle #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        hz.mem_req_X  = 1'b1;
        hz.br_taken_X = 1'b1;
        drv_x(c_LOAD, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        tick();
        tick();
        chk_o("reset_outs", 6'b000000);
        chk("reset_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(hz.flush_cnt), 32'd0);
        idle();
        rst_n = 1'b1;
        tick();
        #1 chk_o("idle_run", 6'b000000);

        // lw x5 ; add x6,x5,x1
        drv_x(c_LOAD, 1'b1, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
        #1 chk_o("load_use_rs1", 6'b110100);
        tick();
        idle();
        #1 chk_o("load_use_one_cycle", 6'b000000);
        chk("load_use_stall_cnt", 32'(hz.stall_cnt), 32'd1);

        drv_x(c_LOAD, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1 chk_o("load_x0", 6'b000000);
        drv_x(c_LOAD, 1'b1, 5'd5, 5'd5, 1'b0, 5'd7, 1'b1);
        #1 chk_o("load_rs2_only_other", 6'b000000);
        drv_x(c_LOAD, 1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
        #1 chk_o("load_use_rs2", 6'b110100);
        drv_x(c_LOAD, 1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1 chk_o("load_no_wen", 6'b000000);
        drv_x(c_ALU, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1 chk_o("alu_no_interlock", 6'b000000);
        idle();
        tick();

        // Memory wait: ready low for 3 cycles
        hz.mem_req_X = 1'b1;
        #1 chk_o("memwait_c1", 6'b111000);
        tick();
        #1 chk_o("memwait_c2", 6'b111000);
        tick();
        #1 chk_o("memwait_c3", 6'b111000);
        tick();
        hz.mem_ready = 1'b1;
        #1 chk_o("memwait_ready", 6'b000000);
        tick();
        idle();
        #1 chk_o("memwait_back_run", 6'b000000);
        chk("memwait_stall_cnt", 32'(hz.stall_cnt), 32'd4);

        // Taken branch, KILL_CYC=2
        hz.br_taken_X = 1'b1;
        #1 chk_o("branch_redirect", 6'b000011);
        tick();
        idle();
        #1 chk_o("branch_kill2", 6'b000010);
        tick();
        #1 chk_o("branch_done", 6'b000000);
        chk("branch_flush_cnt", 32'(hz.flush_cnt), 32'd2);

        // Redirect together with load-use: redirect wins
        drv_x(c_LOAD, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        hz.jump_X = 1'b1;
        #1 chk_o("redir_over_load_use", 6'b000011);
        tick();
        idle();
        #1 chk_o("redir_lu_kill2", 6'b000010);
        tick();

        // Redirect arriving inside the kill window reloads it
        hz.jump_X = 1'b1;
        #1 chk_o("jump_first", 6'b000011);
        tick();
        #1 chk_o("jump_in_kill", 6'b000011);
        tick();
        idle();
        #1 chk_o("jump_reload_kill", 6'b000010);
        tick();
        #1 chk_o("jump_done", 6'b000000);
        chk("flush_cnt_total", 32'(hz.flush_cnt), 32'd7);

        // Memory has priority over a same-cycle redirect
        hz.mem_req_X  = 1'b1;
        hz.br_taken_X = 1'b1;
        #1 chk_o("mem_over_redir", 6'b111000);
        tick();
        hz.br_taken_X = 1'b0;
        hz.mem_ready  = 1'b1;
        #1 chk_o("mem_over_redir_rel", 6'b000000);
        tick();
        idle();
        #1 chk("stall_cnt_5", 32'(hz.stall_cnt), 32'd5);

        // Async reset while in MEMWAIT
        hz.mem_req_X = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1 chk_o("rst_in_memwait_outs", 6'b000000);
        chk("rst_in_memwait_scnt", 32'(hz.stall_cnt), 32'd0);
        idle();
        #1 rst_n = 1'b1;
        tick();
        #1 chk_o("after_rst_run", 6'b000000);

        // Async reset while in KILL
        hz.br_taken_X = 1'b1;
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1 chk_o("rst_in_kill_outs", 6'b000000);
        chk("rst_in_kill_fcnt", 32'(hz.flush_cnt), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        #1 chk_o("after_rst_kill_run", 6'b000000);

        // Clear while stalling
        hz.mem_req_X = 1'b1;
        tick();
        tick();
        #1 chk("pre_clr_scnt", 32'(hz.stall_cnt), 32'd2);
        hz.cnt_clr = 1'b1;
        tick();
        hz.cnt_clr = 1'b0;
        #1 chk("clr_scnt", 32'(hz.stall_cnt), 32'd0);
        hz.mem_ready = 1'b1;
        tick();
        idle();
        #1 chk("post_clr_scnt", 32'(hz.stall_cnt), 32'd0);

        // Wrap of the 4-bit counter
        hz.mem_req_X = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        #1 chk("scnt_max", 32'(hz.stall_cnt), 32'd15);
        tick();
        #1 chk("scnt_wrap", 32'(hz.stall_cnt), 32'd0);
        hz.mem_ready = 1'b1;
        tick();
        idle();
        #1 chk_o("final_run", 6'b000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
